fracnet_mac_pipe: RTL and testbench
===================================

Name: fracnet_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit. Next generation of the fixed 11x11 combinational DSP multiplier used in the FracNet conv datapath.
- Adds configurable operand and accumulator widths, configurable multiplier pipeline depth, and valid/ready handshakes with backpressure.
- Adds first/last framing for dot-product accumulation and optional saturation with a sticky overflow flag.
- Sits between the weight/activation stream readers and the per-channel output buffer.

Parameters:
- A_WIDTH, 11: din0 width, signed.
- B_WIDTH, 11: din1 width, signed.
- ACC_WIDTH, 32: accumulator and dout width. Must be >= A_WIDTH+B_WIDTH; elaboration error otherwise.
- NUM_STAGE, 3: multiplier register stages. Must be >= 1.
- SATURATE, 1: 1 = clamp accumulator on overflow; 0 = two's-complement wrap.

Ports:
- ap_clk, in, 1: clock. All logic on rising edge.
- ap_rst_n, in, 1: reset, synchronous, active-low.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: unit accepts a beat this cycle.
- din0, in, A_WIDTH: signed operand A.
- din1, in, B_WIDTH: signed operand B.
- in_first, in, 1: beat starts a new accumulation.
- in_last, in, 1: beat ends the accumulation; its result is emitted.
- out_valid, out, 1: dout/out_sat valid.
- out_ready, in, 1: downstream accepts result.
- dout, out, ACC_WIDTH: signed accumulated result.
- out_sat, out, 1: overflow occurred at any beat of this accumulation.

Behaviour:
- Reset is synchronous: ap_rst_n=0 at a rising edge clears all stage valids, the accumulator, the sticky flag, out_valid, dout and out_sat to 0. Reset mid-accumulation discards partial state with no output.
- Global advance: en = !out_valid || out_ready. in_ready = en (combinational). A beat is accepted when in_valid && in_ready.
- When en=0 the whole pipeline freezes: stage registers, accumulator and output hold.
- Multiplier pipeline:
  - Full-precision signed product, width A_WIDTH+B_WIDTH.
  - Passes through NUM_STAGE registers, each carrying a valid, first and last flag.
  - Bubbles (valid=0) propagate and never modify the accumulator.
- Accumulate stage, on a valid product p sign-extended to ACC_WIDTH:
  - If first: acc_next = p, and the sticky flag is cleared to 0.
  - Otherwise: acc_next = acc + p, computed at ACC_WIDTH+1 bits.
  - Overflow is defined as the two top bits of the sum differing.
  - SATURATE=1: on overflow, clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) according to the sign of the true sum.
  - SATURATE=0: keep the low ACC_WIDTH bits.
  - Either mode: overflow sets the sticky flag.
- Output register:
  - When a valid last product is accumulated, dout <= acc_next, out_sat <= sticky_next, out_valid <= 1.
  - out_valid clears on out_valid && out_ready unless a new last result loads the same cycle.
  - dout and out_sat hold while out_valid && !out_ready.
- Latency: NUM_STAGE+1 cycles from acceptance of the last beat to out_valid=1, with no stalls.
- Throughput: one beat per cycle while out_ready=1.
- Boundary cases:
  - first && last on the same beat: result = that single product.
  - A beat with first=0 directly after reset accumulates onto 0.
  - last with no preceding first continues the running accumulation.
  - first arriving while the previous result is still held: the previous result is unaffected, since it stalls until consumed.

Decomposition:
- Package fracnet_mac_pkg:
  - Width-check constants.
  - Functions acc_max(ACC_WIDTH) and acc_min(ACC_WIDTH).
  - Sign-extension helper.
  - Flag-bundle typedef {valid, first, last}.
- Sub-module fracnet_mul_pipe:
  - Parametrised by A_WIDTH, B_WIDTH, NUM_STAGE.
  - Ports: ap_clk, ap_rst_n, en, din0, din1, flags in, product out, flags out.
  - Intended for DSP48 inference.
- Accumulator, saturation and output logic live in the top module.

Test Plan:
1. Default params; single beat first=last=1, din0=-1024, din1=-1024 -> out_valid at cycle 4 after accept, dout=1048576, out_sat=0.
2. Four beats (3,5),(-2,7),(10,10),(-1,-1), first on beat 0, last on beat 3, back-to-back -> dout=15-14+100+1=102, exactly one out_valid pulse.
3. ACC_WIDTH=22, SATURATE=1; two beats (-1024,-1024) first..last -> dout=2097151, out_sat=1. Repeat with SATURATE=0 -> dout=-2097152, out_sat=1.
4. Backpressure: out_ready=0 for 5 cycles while result pending and in_valid=1 -> in_ready=0, dout stable, no beat lost. Then out_ready=1 -> next result correct.
5. Reset: ap_rst_n=0 for one cycle mid-accumulation after 2 beats -> out_valid=0, dout=0. A following first..last of (2,3) yields 6.
6. NUM_STAGE=1, alternating valid/bubble input with first=last every beat -> latency 2 cycles, bubbles produce no output.

Source files
------------

// File: rtl/fracnet_mac_pkg.sv
// Shared types, width limits and helper functions for the FracNet MAC pipeline.
package fracnet_mac_pkg;

    // Limits checked at elaboration by the MAC top.
    localparam int MAX_ACC_WIDTH = 64;
    localparam int MIN_NUM_STAGE = 1;

    // Per-beat control flags carried alongside the product.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } mac_flags_t;

    // Largest positive value representable in a w-bit signed accumulator.
    function automatic logic signed [MAX_ACC_WIDTH-1:0] acc_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative value representable in a w-bit signed accumulator.
    function automatic logic signed [MAX_ACC_WIDTH-1:0] acc_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Sign-extend the low w bits of v to the full 64 bits.
    function automatic logic signed [MAX_ACC_WIDTH-1:0] sext(input logic [MAX_ACC_WIDTH-1:0] v,
                                                             input int w);
        logic [MAX_ACC_WIDTH-1:0] r;
        for (int i = 0; i < MAX_ACC_WIDTH; i++) begin
            r[i] = (i < w) ? v[i] : v[w-1];
        end
        return $signed(r);
    endfunction

endpackage

// File: rtl/fracnet_mul_pipe.sv
// Full-precision signed multiplier followed by NUM_STAGE registers; the flag
// bundle travels in lock-step with the product. Shaped for DSP48 inference.
module fracnet_mul_pipe
    import fracnet_mac_pkg::*;
#(
    parameter int A_WIDTH   = 11,
    parameter int B_WIDTH   = 11,
    parameter int NUM_STAGE = 3
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst_n,
    input  logic                               en,
    input  logic signed [A_WIDTH-1:0]          din0,
    input  logic signed [B_WIDTH-1:0]          din1,
    input  mac_flags_t                         flags_in,
    output logic signed [A_WIDTH+B_WIDTH-1:0]  prod,
    output mac_flags_t                         flags_out
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic signed [P_WIDTH-1:0] prod_p [NUM_STAGE];
    mac_flags_t                flg_p  [NUM_STAGE];

    // Product data registers: no reset so the DSP pipeline registers can absorb them.
    always_ff @(posedge ap_clk) begin
        if (en) begin
            prod_p[0] <= P_WIDTH'(din0) * P_WIDTH'(din1);
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_p[i] <= prod_p[i-1];
            end
        end
    end

    // Flag registers: reset clears every stage so in-flight beats are dropped.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                flg_p[i] <= '0;
            end
        end else if (en) begin
            flg_p[0] <= flags_in;
            for (int i = 1; i < NUM_STAGE; i++) begin
                flg_p[i] <= flg_p[i-1];
            end
        end
    end

    assign prod      = prod_p[NUM_STAGE-1];
    assign flags_out = flg_p[NUM_STAGE-1];

endmodule

// File: rtl/fracnet_mac_pipe.sv
// Pipelined signed multiply-accumulate with first/last framing, optional
// saturation with a sticky overflow flag, and valid/ready backpressure.
module fracnet_mac_pipe
    import fracnet_mac_pkg::*;
#(
    parameter int A_WIDTH   = 11,
    parameter int B_WIDTH   = 11,
    parameter int ACC_WIDTH = 32,
    parameter int NUM_STAGE = 3,
    parameter int SATURATE  = 1
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [A_WIDTH-1:0]   din0,
    input  logic signed [B_WIDTH-1:0]   din1,
    input  logic                        in_first,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] dout,
    output logic                        out_sat
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    if (ACC_WIDTH < P_WIDTH) begin : g_chk_acc_narrow
        $error("fracnet_mac_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
    if (ACC_WIDTH > MAX_ACC_WIDTH) begin : g_chk_acc_wide
        $error("fracnet_mac_pipe: ACC_WIDTH exceeds supported maximum");
    end
    if (NUM_STAGE < MIN_NUM_STAGE) begin : g_chk_stage
        $error("fracnet_mac_pipe: NUM_STAGE must be >= 1");
    end

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(acc_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(acc_min(ACC_WIDTH));

    // Clamp or wrap the (ACC_WIDTH+1)-bit sum back into the accumulator width.
    function automatic logic signed [ACC_WIDTH-1:0] sat_or_wrap(input logic signed [ACC_WIDTH:0] s);
        if ((SATURATE != 0) && (s[ACC_WIDTH] != s[ACC_WIDTH-1])) begin
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_WIDTH-1:0];
    endfunction

    logic                        en;
    mac_flags_t                  in_flags;
    mac_flags_t                  mul_flags;
    logic signed [P_WIDTH-1:0]   mul_prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH:0]   sum;
    logic                        ovf;
    logic                        sticky;
    logic                        sticky_next;

    // The whole pipeline moves only when the output slot is free or being drained.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign in_flags = {in_valid, in_first, in_last};

    fracnet_mul_pipe #(
        .A_WIDTH   (A_WIDTH),
        .B_WIDTH   (B_WIDTH),
        .NUM_STAGE (NUM_STAGE)
    ) u_mul (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .en        (en),
        .din0      (din0),
        .din1      (din1),
        .flags_in  (in_flags),
        .prod      (mul_prod),
        .flags_out (mul_flags)
    );

    assign prod_ext = ACC_WIDTH'(sext(64'($unsigned(mul_prod)), P_WIDTH));

    // Next accumulator value: a first beat restarts from zero with a clean sticky flag.
    always_comb begin
        acc_base    = mul_flags.first ? '0 : acc;
        sum         = {acc_base[ACC_WIDTH-1], acc_base} + {prod_ext[ACC_WIDTH-1], prod_ext};
        ovf         = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        acc_next    = sat_or_wrap(sum);
        sticky_next = (mul_flags.first ? 1'b0 : sticky) | ovf;
    end

    // Accumulator and output register; bubbles leave the accumulator untouched.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            if (mul_flags.valid) begin
                acc    <= acc_next;
                sticky <= sticky_next;
            end
            out_valid <= mul_flags.valid && mul_flags.last;
            if (mul_flags.valid && mul_flags.last) begin
                dout    <= acc_next;
                out_sat <= sticky_next;
            end
        end
    end

endmodule

// File: tb/tb_fracnet_mac_pipe.sv
// Bench for fracnet_mac_pipe: four parameterisations, directed beats, and a
// transaction-level accumulate model checked against every valid output.
module tb_fracnet_mac_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults, 1: ACC 22 saturating, 2: ACC 22 wrapping, 3: NUM_STAGE 1.
    logic               rst_n     [4];
    logic               in_valid  [4];
    logic               in_ready  [4];
    logic signed [10:0] a_in      [4];
    logic signed [10:0] b_in      [4];
    logic               in_first  [4];
    logic               in_last   [4];
    logic               out_valid [4];
    logic               out_ready [4];
    logic               out_sat   [4];
    logic signed [31:0] dq        [4];
    logic signed [21:0] d1, d2;

    assign dq[1] = 32'(d1);
    assign dq[2] = 32'(d2);

    fracnet_mac_pipe u0 (
        .ap_clk(clk), .ap_rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .din0(a_in[0]), .din1(b_in[0]), .in_first(in_first[0]), .in_last(in_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .dout(dq[0]), .out_sat(out_sat[0]));

    fracnet_mac_pipe #(.ACC_WIDTH(22), .SATURATE(1)) u1 (
        .ap_clk(clk), .ap_rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .din0(a_in[1]), .din1(b_in[1]), .in_first(in_first[1]), .in_last(in_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .dout(d1), .out_sat(out_sat[1]));

    fracnet_mac_pipe #(.ACC_WIDTH(22), .SATURATE(0)) u2 (
        .ap_clk(clk), .ap_rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .din0(a_in[2]), .din1(b_in[2]), .in_first(in_first[2]), .in_last(in_last[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .dout(d2), .out_sat(out_sat[2]));

    fracnet_mac_pipe #(.NUM_STAGE(1)) u3 (
        .ap_clk(clk), .ap_rst_n(rst_n[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .din0(a_in[3]), .din1(b_in[3]), .in_first(in_first[3]), .in_last(in_last[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .dout(dq[3]), .out_sat(out_sat[3]));

    // Model configuration per instance.
    int acc_w [4] = '{32, 22, 22, 32};
    bit sat_m [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    typedef struct {
        longint v;
        bit     s;
    } exp_t;

    exp_t   exp_q    [4][$];
    longint m_acc    [4];
    bit     m_sticky [4];
    int     hs_cnt   [4];

    int nchk  = 0;
    int npass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Accepted beat -> model: plain integer arithmetic with range clamp or modular wrap.
    function automatic void model_beat(input int d);
        longint p, s, mx, mn, span;
        p    = longint'(a_in[d]) * longint'(b_in[d]);
        mx   = (64'sd1 <<< (acc_w[d] - 1)) - 1;
        mn   = -(64'sd1 <<< (acc_w[d] - 1));
        span = 64'sd1 <<< acc_w[d];
        if (in_first[d]) begin
            m_acc[d]    = p;
            m_sticky[d] = 1'b0;
        end else begin
            s = m_acc[d] + p;
            if (s > mx || s < mn) begin
                m_sticky[d] = 1'b1;
                if (sat_m[d]) s = (s > mx) ? mx : mn;
                else begin
                    s = s & (span - 1);
                    if (s > mx) s = s - span;
                end
            end
            m_acc[d] = s;
        end
        if (in_last[d]) exp_q[d].push_back('{v: m_acc[d], s: m_sticky[d]});
    endfunction

    // Compare process: sample half a cycle away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (!rst_n[d]) begin
                exp_q[d].delete();
                m_acc[d]    = 0;
                m_sticky[d] = 1'b0;
            end else begin
                if (out_valid[d]) begin
                    if (exp_q[d].size() == 0) begin
                        chk($sformatf("u%0d_unexpected_out_valid", d), 1, 0);
                    end else begin
                        chk($sformatf("u%0d_dout_model", d), dq[d], exp_q[d][0].v);
                        chk($sformatf("u%0d_sat_model", d), longint'(out_sat[d]), longint'(exp_q[d][0].s));
                        if (out_ready[d]) begin
                            void'(exp_q[d].pop_front());
                            hs_cnt[d]++;
                        end
                    end
                end
                if (in_valid[d] && in_ready[d]) model_beat(d);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and hold it until the DUT accepts it; returns #1 after the accept edge.
    task automatic send(input int d, input int a, input int b, input bit f, input bit l);
        bit done;
        int guard;
        done  = 1'b0;
        guard = 0;
        in_valid[d] = 1'b1;
        a_in[d]     = 11'(a);
        b_in[d]     = 11'(b);
        in_first[d] = f;
        in_last[d]  = l;
        while (!done) begin
            @(negedge clk);
            done = in_ready[d];
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 200) begin
                $display("FAIL send_timeout_u%0d: got no accept, expected accept within 200 cycles", d);
                $fatal(1, "beat never accepted");
            end
        end
        in_valid[d] = 1'b0;
    endtask

    // Wait (bounded) for out_valid and check against hand-computed values; lat counts
    // cycles after the accept cycle of the most recent send.
    task automatic wait_result(input int d, input longint v, input bit s, input string nm,
                               output int lat);
        int k;
        k = 1;
        while (!out_valid[d] && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        lat = k;
        if (!out_valid[d]) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            chk({nm, "_dout"}, dq[d], v);
            chk({nm, "_sat"}, longint'(out_sat[d]), longint'(s));
        end
    endtask

    initial begin
        int lat;
        int n0;
        for (int d = 0; d < 4; d++) begin
            rst_n[d]     = 1'b0;
            in_valid[d]  = 1'b0;
            a_in[d]      = '0;
            b_in[d]      = '0;
            in_first[d]  = 1'b0;
            in_last[d]   = 1'b0;
            out_ready[d] = 1'b1;
            hs_cnt[d]    = 0;
        end
        tick(2);
        for (int d = 0; d < 4; d++) rst_n[d] = 1'b1;

        // Reset state.
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("u%0d_rst_out_valid", d), longint'(out_valid[d]), 0);
            chk($sformatf("u%0d_rst_dout", d), dq[d], 0);
            chk($sformatf("u%0d_rst_out_sat", d), longint'(out_sat[d]), 0);
            chk($sformatf("u%0d_rst_in_ready", d), longint'(in_ready[d]), 1);
        end

        // Single first+last beat, latency NUM_STAGE+1.
        send(0, -1024, -1024, 1'b1, 1'b1);
        wait_result(0, 1048576, 1'b0, "single_beat", lat);
        chk("single_beat_latency", lat, 4);
        tick(2);

        // Four back-to-back beats, one result pulse.
        n0 = hs_cnt[0];
        send(0, 3, 5, 1'b1, 1'b0);
        send(0, -2, 7, 1'b0, 1'b0);
        send(0, 10, 10, 1'b0, 1'b0);
        send(0, -1, -1, 1'b0, 1'b1);
        wait_result(0, 102, 1'b0, "dot4", lat);
        tick(10);
        chk("dot4_pulse_count", hs_cnt[0] - n0, 1);

        // Narrow accumulator overflow: clamp then wrap.
        send(1, -1024, -1024, 1'b1, 1'b0);
        send(1, -1024, -1024, 1'b0, 1'b1);
        wait_result(1, 2097151, 1'b1, "sat_clamp", lat);
        tick(2);
        send(1, 2, 3, 1'b1, 1'b1);
        wait_result(1, 6, 1'b0, "sat_sticky_clear", lat);
        send(2, -1024, -1024, 1'b1, 1'b0);
        send(2, -1024, -1024, 1'b0, 1'b1);
        wait_result(2, -2097152, 1'b1, "wrap", lat);
        tick(2);

        // Backpressure: result held, next beat stalled, then delivered.
        out_ready[0] = 1'b0;
        send(0, 7, 8, 1'b1, 1'b1);
        wait_result(0, 56, 1'b0, "bp_held", lat);
        in_valid[0] = 1'b1;
        a_in[0]     = -11'sd3;
        b_in[0]     = 11'sd4;
        in_first[0] = 1'b1;
        in_last[0]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("bp_in_ready_low", longint'(in_ready[0]), 0);
            chk("bp_dout_stable", dq[0], 56);
        end
        out_ready[0] = 1'b1;
        send(0, -3, 4, 1'b1, 1'b1);
        wait_result(0, -12, 1'b0, "bp_next", lat);
        tick(2);

        // Reset mid-accumulation.
        send(0, 5, 5, 1'b1, 1'b0);
        send(0, 6, 6, 1'b0, 1'b0);
        rst_n[0] = 1'b0;
        tick(1);
        rst_n[0] = 1'b1;
        chk("midrst_out_valid", longint'(out_valid[0]), 0);
        chk("midrst_dout", dq[0], 0);
        tick(5);
        chk("midrst_no_output", longint'(out_valid[0]), 0);
        send(0, 2, 3, 1'b1, 1'b1);
        wait_result(0, 6, 1'b0, "post_rst", lat);
        tick(2);

        // first=0 right after reset accumulates onto 0; last without first continues.
        rst_n[0] = 1'b0;
        tick(1);
        rst_n[0] = 1'b1;
        send(0, 4, -5, 1'b0, 1'b1);
        wait_result(0, -20, 1'b0, "no_first_after_rst", lat);
        tick(2);
        send(0, 3, 3, 1'b0, 1'b1);
        wait_result(0, -11, 1'b0, "continue_no_first", lat);
        tick(2);

        // NUM_STAGE=1 with alternating beats and bubbles.
        n0 = hs_cnt[3];
        send(3, 3, 4, 1'b1, 1'b1);
        chk("ns1_b0_not_yet", longint'(out_valid[3]), 0);
        tick(1);
        chk("ns1_b0_lat2", longint'(out_valid[3]), 1);
        chk("ns1_b0_dout", dq[3], 12);
        send(3, -5, 6, 1'b1, 1'b1);
        chk("ns1_bubble0", longint'(out_valid[3]), 0);
        tick(1);
        chk("ns1_b1_dout", dq[3], -30);
        send(3, -1024, 1023, 1'b1, 1'b1);
        chk("ns1_bubble1", longint'(out_valid[3]), 0);
        tick(1);
        chk("ns1_b2_dout", dq[3], -1047552);
        send(3, 0, 9, 1'b1, 1'b1);
        chk("ns1_bubble2", longint'(out_valid[3]), 0);
        tick(1);
        chk("ns1_b3_valid", longint'(out_valid[3]), 1);
        chk("ns1_b3_dout", dq[3], 0);
        tick(6);
        chk("ns1_pulse_count", hs_cnt[3] - n0, 4);

        // Every expected result must have been delivered.
        tick(10);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("u%0d_queue_drained", d), exp_q[d].size(), 0);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
